// File: rtl/banked_data_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : banked_data_ram                                              |
// | Description : Multi-context single-port-style data RAM. The active bank    |
// |               register selects one of NUM_BANKS windows. Reads are         |
// |               registered and read-first. A sweep FSM zeroes the active     |
// |               bank on request. Defining BANKED_RAM_BYTE_MASK_EN adds the   |
// |               byte-enable input `be`.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module banked_data_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] endereco_escrita,
  input  logic [ADDR_WIDTH-1:0] endereco_leitura,
  input  logic                  we,
  input  logic                  re,
  input  logic [BANK_BITS-1:0]  bank_sel,
  input  logic                  bank_load,
  input  logic                  clear_req,
`ifdef BANKED_RAM_BYTE_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] be,
`endif
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  bank_err,
  output logic [BANK_BITS-1:0]  active_bank
);

  localparam int c_mem_depth = NUM_BANKS << ADDR_WIDTH;
  localparam int c_idx_w     = BANK_BITS + ADDR_WIDTH;
  localparam int c_nbytes    = DATA_WIDTH / 8;
  localparam logic [BANK_BITS:0]    c_num_banks = (BANK_BITS + 1)'(NUM_BANKS);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_next;
  logic                  r_clear_done;
  logic                  w_clear_done_next;

  logic [BANK_BITS-1:0]  r_active_bank;
  logic                  r_bank_err;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_q_valid;

  logic [DATA_WIDTH-1:0] r_mem [c_mem_depth];

  logic                  w_idle;
  logic                  w_sweep_wr;
  logic                  w_mem_we;
  logic                  w_rd;
  logic                  w_bank_ok;
  logic                  w_load_ok;
  logic                  w_load_bad;
  logic [c_idx_w-1:0]    w_wr_idx;
  logic [c_idx_w-1:0]    w_rd_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [c_nbytes-1:0]   w_byte_we;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_sweep_wr = (r_state == ST_CLEAR);
  // Reset blocks the memory write too, so an aborted sweep leaves the current word intact.
  assign w_mem_we   = !reset && ((we && w_idle) || w_sweep_wr);
  assign w_rd       = re && w_idle;
  assign w_wr_idx   = {r_active_bank, (w_sweep_wr ? r_cnt : endereco_escrita)};
  assign w_rd_idx   = {r_active_bank, endereco_leitura};
  assign w_wr_data  = w_sweep_wr ? '0 : data;

`ifdef BANKED_RAM_BYTE_MASK_EN
  assign w_byte_we  = w_sweep_wr ? {c_nbytes{1'b1}} : be;
`else
  assign w_byte_we  = {c_nbytes{1'b1}};
`endif

  assign w_bank_ok  = ({1'b0, bank_sel} < c_num_banks);
  assign w_load_ok  = bank_load && w_idle && w_bank_ok;
  assign w_load_bad = bank_load && w_idle && !w_bank_ok;

  // Sweep FSM: next-state and counter logic
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_clear_done_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_next = ST_CLEAR;
          w_cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == c_last_addr) begin
          w_state_next      = ST_IDLE;
          w_cnt_next        = '0;
          w_clear_done_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_clear_done <= w_clear_done_next;
    end
  end

  // The sweep started in the same cycle as a bank load uses the new bank, since it begins next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_active_bank <= '0;
      r_bank_err    <= 1'b0;
    end else begin
      r_bank_err <= w_load_bad;
      if (w_load_ok) begin
        r_active_bank <= bank_sel;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int b = 0; b < c_nbytes; b++) begin
        if (w_byte_we[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read-first: the array read samples the pre-write contents of the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= w_rd;
      if (w_rd) begin
        r_q <= r_mem[w_rd_idx];
      end
    end
  end

  assign q           = r_q;
  assign q_valid     = r_q_valid;
  assign busy        = w_sweep_wr;
  assign clear_done  = r_clear_done;
  assign bank_err    = r_bank_err;
  assign active_bank = r_active_bank;

endmodule
`default_nettype wire

// File: doc/banked_data_ram.md
BANKED_DATA_RAM -- requirements
Module: banked_data_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, bank-local address width; bank depth = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter NUM_BANKS, default 2, number of context banks (1..16).
REQ-004 SHALL have parameter BANK_BITS, default 1, bank index width (>= clog2(NUM_BANKS), minimum 1).
REQ-005 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port data, input, DATA_WIDTH, write data.
REQ-008 SHALL have port endereco_escrita, input, ADDR_WIDTH, bank-local write address.
REQ-009 SHALL have port endereco_leitura, input, ADDR_WIDTH, bank-local read address.
REQ-010 SHALL have port we, input, 1, write enable.
REQ-011 SHALL have port re, input, 1, read enable.
REQ-012 SHALL have port bank_sel, input, BANK_BITS, bank index to load.
REQ-013 SHALL have port bank_load, input, 1, load bank_sel into the active-bank register.
REQ-014 SHALL have port clear_req, input, 1, start zeroing the active bank.
REQ-015 SHALL have port q, output, DATA_WIDTH, registered read data.
REQ-016 SHALL have port q_valid, output, 1, q updated this cycle.
REQ-017 SHALL have port busy, output, 1, clear sweep in progress.
REQ-018 SHALL have port clear_done, output, 1, one-cycle pulse at sweep end.
REQ-019 SHALL have port bank_err, output, 1, one-cycle pulse on rejected bank_load.
REQ-020 SHALL have port active_bank, output, BANK_BITS, current bank register.

Function
REQ-021 SHALL store NUM_BANKS*2^ADDR_WIDTH words; physical index = {active_bank, bank-local address}.
REQ-022 SHALL write data at the physical write index on the edge where we=1 and busy=0.
REQ-023 SHALL register the read word into q one cycle after re=1 with busy=0, with q_valid=1 that cycle; q SHALL hold its value otherwise, and q_valid SHALL be 0 otherwise.
REQ-024 SHALL return the old word (read-first) when read and write hit the same physical index in the same cycle.
REQ-025 SHALL update active_bank from bank_sel at the edge of bank_load=1 when bank_sel < NUM_BANKS and busy=0; accesses issued in that same cycle SHALL use the old bank.
REQ-026 SHALL keep active_bank unchanged and pulse bank_err the next cycle when bank_load=1 and bank_sel >= NUM_BANKS; bank_load while busy=1 SHALL be ignored without bank_err.
REQ-027 SHALL implement an FSM with states IDLE and CLEAR; IDLE -> CLEAR on clear_req=1, sweep counter set to 0.
REQ-028 In CLEAR, SHALL write zero to {active_bank, counter} every cycle, increment the counter, and hold busy=1.
REQ-029 SHALL leave CLEAR after writing index 2^ADDR_WIDTH-1 (sweep lasts exactly 2^ADDR_WIDTH cycles), assert clear_done for one cycle and return to IDLE with busy=0.
REQ-030 SHALL ignore we, re and clear_req while busy=1.
REQ-031 When clear_req and bank_load coincide in IDLE, SHALL apply the bank load first and clear the newly loaded bank.

Reset
REQ-032 On reset=1 at a clock edge, SHALL set active_bank=0, q=0, q_valid=0, busy=0, clear_done=0, bank_err=0, FSM=IDLE, counter=0.
REQ-033 SHALL NOT initialise memory contents on reset; reset during CLEAR SHALL abort the sweep, leaving already-swept words zero and the rest intact.
REQ-034 SHALL give reset priority over every other input in the same cycle.

Configuration
REQ-035 With macro BANKED_RAM_BYTE_MASK_EN defined, SHALL add input be (DATA_WIDTH/8 bits), and user writes SHALL update only bytes whose be bit is 1; clear sweeps SHALL always write all bytes.
REQ-036 Without BANKED_RAM_BYTE_MASK_EN, port be SHALL be absent and every write SHALL update the full word.

Verification
REQ-037 Bank isolation: bank 0 write addr 5 = 0xAAAA_0001, bank 1 write addr 5 = 0xBBBB_0002, read addr 5 per bank -> 0xAAAA_0001 / 0xBBBB_0002, q_valid one cycle after re.
REQ-038 Read-during-write: addr 3 holds 0x11, same cycle write 0x22 and read addr 3 -> q=0x11; next read -> 0x22.
REQ-039 Clear: fill bank 1 with 0xFFFF_FFFF, clear_req -> busy high exactly 64 cycles, clear_done pulse, bank 1 reads 0, bank 0 unchanged.
REQ-040 Bad bank: NUM_BANKS=3, BANK_BITS=2, bank_load with bank_sel=3 -> bank_err pulse, active_bank unchanged.
REQ-041 Reset mid-clear: reset at sweep cycle 10 of a full bank -> busy=0 next cycle, addrs 0..9 read 0, addr 10..63 keep prior data.
REQ-042 Byte mask (macro defined): word 0x1234_5678, write 0xAABB_CCDD with be=4'b0101 -> read 0x12BB_56DD.
